// File: rtl/cbus_sram.sv
// cbus_sram: behavioural cache-bus slave memory. Accepts single-word and
// burst reads and writes, inserts a fixed first-beat latency, streams one
// beat per cycle and flags the final beat with cresp_last. The whole array
// is exported on mem so an outside observer can compare against it.
module cbus_sram #(
    parameter int WORDS   = 16,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  creq_valid,
    input  logic                  creq_is_write,
    input  logic [2:0]            creq_size,
    input  logic [31:0]           creq_addr,
    input  logic [3:0]            creq_strobe,
    input  logic [31:0]           creq_data,
    input  logic [3:0]            creq_len,
    input  logic [1:0]            creq_burst,
    output logic                  cresp_ready,
    output logic                  cresp_last,
    output logic [31:0]           cresp_data,
    output logic [WORDS*32-1:0]   mem
);

    localparam int AW = $clog2(WORDS);
    // Guarded so a zero-latency build never evaluates LATENCY-1 as negative.
    localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

    state_t         state, state_d;
    logic [AW-1:0]  base_q;
    logic [3:0]     len_q;
    logic           wr_q;
    logic [3:0]     cnt_q;
    logic [3:0]     wcnt_q;
    logic [31:0]    ram [WORDS];
    logic [AW-1:0]  idx;
    logic           beat;
    logic           unused_bits;

    // Address bits outside the word index, size and burst type are ignored.
    assign unused_bits = ^{creq_size, creq_burst, creq_addr[31:AW+2], creq_addr[1:0]};

    // Word index of the current beat; INCR bursts wrap at the array end.
    always_comb begin
        idx  = base_q + AW'(cnt_q);
        beat = (state == BURST) && creq_valid;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; a dropped valid in WAIT or BURST aborts to IDLE.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (creq_valid) begin
                    state_d = (LATENCY > 0) ? WAIT : BURST;
                end
            end
            WAIT: begin
                if (!creq_valid) begin
                    state_d = IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!creq_valid) begin
                    state_d = IDLE;
                end else if (cnt_q == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction fields, beat counter and latency down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            wr_q   <= 1'b0;
            cnt_q  <= '0;
            wcnt_q <= '0;
        end else begin
            if (state == IDLE && creq_valid) begin
                base_q <= creq_addr[AW+1:2];
                len_q  <= creq_len;
                wr_q   <= creq_is_write;
                cnt_q  <= '0;
                wcnt_q <= WAIT_LOAD;
            end
            if (state == WAIT && wcnt_q != 4'd0) begin
                wcnt_q <= wcnt_q - 4'd1;
            end
            if (beat) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    // Memory array: cleared on reset, byte-strobed write on each write beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                ram[i] <= '0;
            end
        end else if (beat && wr_q) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (creq_strobe[b]) begin
                    ram[idx][b*8 +: 8] <= creq_data[b*8 +: 8];
                end
            end
        end
    end

    // Response outputs, combinational from state and the live valid.
    always_comb begin
        cresp_ready = beat;
        cresp_last  = beat && (cnt_q == len_q);
        cresp_data  = (state == BURST) ? ram[idx] : '0;
    end

    // Flattened view of the array for external inspection.
    always_comb begin
        mem = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            mem[i*32 +: 32] = ram[i];
        end
    end

endmodule

// File: tb/tb_cbus_sram.sv
// tb_cbus_sram: directed checks of cbus_sram. Instance "dut" uses the
// default two-cycle latency; "dut0" is a zero-latency build used for the
// back-to-back acceptance pattern.
module tb_cbus_sram;

    localparam int WORDS = 16;
    localparam int LAT   = 2;

    logic                clk;
    logic                reset;

    logic                a_valid, a_is_write;
    logic [2:0]          a_size;
    logic [31:0]         a_addr, a_data;
    logic [3:0]          a_strobe, a_len;
    logic [1:0]          a_burst;
    logic                a_ready, a_last;
    logic [31:0]         a_rdata;
    logic [WORDS*32-1:0] a_mem;

    logic                b_valid, b_is_write;
    logic [2:0]          b_size;
    logic [31:0]         b_addr, b_data;
    logic [3:0]          b_strobe, b_len;
    logic [1:0]          b_burst;
    logic                b_ready, b_last;
    logic [31:0]         b_rdata;
    logic [WORDS*32-1:0] b_mem;

    logic [31:0]         wdata [16];
    logic [31:0]         rexp  [16];

    int nvec;
    int nfail;

    cbus_sram #(.WORDS(WORDS), .LATENCY(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .creq_valid    (a_valid),
        .creq_is_write (a_is_write),
        .creq_size     (a_size),
        .creq_addr     (a_addr),
        .creq_strobe   (a_strobe),
        .creq_data     (a_data),
        .creq_len      (a_len),
        .creq_burst    (a_burst),
        .cresp_ready   (a_ready),
        .cresp_last    (a_last),
        .cresp_data    (a_rdata),
        .mem           (a_mem)
    );

    cbus_sram #(.WORDS(WORDS), .LATENCY(0)) dut0 (
        .clk           (clk),
        .reset         (reset),
        .creq_valid    (b_valid),
        .creq_is_write (b_is_write),
        .creq_size     (b_size),
        .creq_addr     (b_addr),
        .creq_strobe   (b_strobe),
        .creq_data     (b_data),
        .creq_len      (b_len),
        .creq_burst    (b_burst),
        .cresp_ready   (b_ready),
        .cresp_last    (b_last),
        .cresp_data    (b_rdata),
        .mem           (b_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector, reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] memw(input int i);
        return a_mem[i*32 +: 32];
    endfunction

    // One transaction on dut, started from IDLE. Write beats take wdata[],
    // read beats are checked against rexp[]. If abort_at >= 0, valid drops
    // in place of that beat.
    task automatic run(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                       input logic [3:0] strb, input int abort_at, input string name);
        a_valid    = 1'b1;
        a_is_write = wr;
        a_addr     = addr;
        a_len      = len;
        a_strobe   = strb;
        a_data     = wdata[0];
        #1 chk($sformatf("%s.accept_rdy", name), 32'(a_ready), 32'd0);
        tick();
        for (int w = 0; w < LAT; w++) begin
            #1 chk($sformatf("%s.wait%0d_rdy", name, w), 32'(a_ready), 32'd0);
            tick();
        end
        for (int b = 0; b <= int'(len); b++) begin
            a_data = wdata[b];
            if (b == abort_at) begin
                a_valid = 1'b0;
                #1 chk($sformatf("%s.abort_rdy", name), 32'(a_ready), 32'd0);
                tick();
                return;
            end
            #1;
            chk($sformatf("%s.b%0d_rdy", name, b), 32'(a_ready), 32'd1);
            chk($sformatf("%s.b%0d_last", name, b), 32'(a_last), 32'(b == int'(len)));
            if (!wr) begin
                chk($sformatf("%s.b%0d_data", name, b), a_rdata, rexp[b]);
            end
            tick();
        end
        #1 chk($sformatf("%s.done_rdy", name), 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nvec  = 0;
        nfail = 0;
        reset = 1'b1;
        a_valid = 1'b0; a_is_write = 1'b0; a_size = 3'd2; a_addr = '0;
        a_data  = '0;   a_strobe   = '0;   a_len  = '0;   a_burst = 2'd1;
        b_valid = 1'b0; b_is_write = 1'b0; b_size = 3'd2; b_addr = '0;
        b_data  = '0;   b_strobe   = '0;   b_len  = '0;   b_burst = 2'd1;
        for (int i = 0; i < 16; i++) begin
            wdata[i] = '0;
            rexp[i]  = '0;
        end

        // Reset state.
        tick();
        tick();
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_last",  32'(a_last),  32'd0);
        chk("rst_data",  a_rdata,      32'd0);
        chk("rst_mem",   32'(a_mem == '0), 32'd1);
        reset = 1'b0;
        tick();

        // Single read of zeroed word 2.
        rexp[0] = 32'd0;
        run(1'b0, 32'h8, 4'd0, 4'h0, -1, "rd1");

        // Four-beat full-word write to words 4..7.
        wdata[0] = 32'h11111111; wdata[1] = 32'h22222222;
        wdata[2] = 32'h33333333; wdata[3] = 32'h44444444;
        run(1'b1, 32'h10, 4'd3, 4'hF, -1, "wr4");
        chk("wr4.m4", memw(4), 32'h11111111);
        chk("wr4.m5", memw(5), 32'h22222222);
        chk("wr4.m6", memw(6), 32'h33333333);
        chk("wr4.m7", memw(7), 32'h44444444);
        chk("wr4.m8", memw(8), 32'h00000000);

        // Partial write through byte strobes 0 and 2.
        wdata[0] = 32'h12345678;
        run(1'b1, 32'h24, 4'd0, 4'hF, -1, "pw_a");
        wdata[0] = 32'hAABBCCDD;
        run(1'b1, 32'h24, 4'd0, 4'h5, -1, "pw_b");
        chk("pw.m9", memw(9), 32'h12BB56DD);
        rexp[0] = 32'h12BB56DD;
        run(1'b0, 32'h24, 4'd0, 4'h0, -1, "pw_rd");

        // Fill mem[i] = i, then a 16-beat read from word 14 that wraps.
        for (int i = 0; i < 16; i++) wdata[i] = 32'(i);
        run(1'b1, 32'h0, 4'd15, 4'hF, -1, "fill");
        chk("fill.m15", memw(15), 32'd15);
        for (int i = 0; i < 16; i++) rexp[i] = 32'((14 + i) % 16);
        run(1'b0, 32'h38, 4'd15, 4'h0, -1, "wrap");

        // Abort a 4-beat write after two beats.
        wdata[0] = 32'hA0A0A0A0; wdata[1] = 32'hA1A1A1A1;
        wdata[2] = 32'hA2A2A2A2; wdata[3] = 32'hA3A3A3A3;
        run(1'b1, 32'h10, 4'd3, 4'hF, 2, "abt");
        chk("abt.m4", memw(4), 32'hA0A0A0A0);
        chk("abt.m5", memw(5), 32'hA1A1A1A1);
        chk("abt.m6", memw(6), 32'd6);
        chk("abt.m7", memw(7), 32'd7);
        rexp[0] = 32'hA1A1A1A1;
        run(1'b0, 32'h14, 4'd0, 4'h0, -1, "abt_rd");

        // Reset asserted during the second beat of a write burst.
        wdata[0] = 32'hDEADBEEF;
        a_valid = 1'b1; a_is_write = 1'b1; a_addr = 32'h0; a_len = 4'd3;
        a_strobe = 4'hF; a_data = wdata[0];
        tick();
        tick();
        tick();
        #1 chk("mrst.b0_rdy", 32'(a_ready), 32'd1);
        tick();
        chk("mrst.m0_before", memw(0), 32'hDEADBEEF);
        a_data = 32'h55555555;
        reset  = 1'b1;
        #1;
        chk("mrst.ready", 32'(a_ready), 32'd0);
        chk("mrst.last",  32'(a_last),  32'd0);
        chk("mrst.data",  a_rdata,      32'd0);
        chk("mrst.mem",   32'(a_mem == '0), 32'd1);
        a_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("mrst.m1_after", memw(1), 32'd0);

        // Zero-latency build: held valid yields ready on every third cycle.
        b_valid = 1'b1; b_is_write = 1'b0; b_addr = 32'h0; b_len = 4'd0;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("lat0.c%0d_rdy", k), 32'(b_ready), 32'((k % 3) == 1));
            chk($sformatf("lat0.c%0d_last", k), 32'(b_last), 32'((k % 3) == 1));
            tick();
        end
        b_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
